// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - Data-memory responder with req/ack handshake, programmable wait states and byte-enabled word array
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;
    logic        access;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        err_q;

    logic              addr_err;
    logic [ADDR_W-1:0] word_idx;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_INIT;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter only counts down and stops at zero, so 15 never wraps.
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Request fields are frozen at acceptance; the in-flight access uses only these copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
    assign word_idx = addr_q[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            rdata <= 32'h0;
        end else if (access) begin
            err_q <= addr_err;
            if (!we_q && !addr_err) begin
                rdata <= mem[word_idx];
            end
        end
    end

    // Array has no reset; state is forced to IDLE during reset so no write can slip through.
    always_ff @(posedge clk) begin
        if (access && we_q && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ack  = (state == S_RESP);
    assign err  = ack & err_q;
    assign busy = (state != S_IDLE);

endmodule
